// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, types and helpers for the negacyclic NTT engine.
//   DEF_W / DEF_N / DEF_LOGN : default word width, ring size and log2(ring size)
//   word_t                   : one coefficient / modulus word
//   state_t                  : engine control states
//   bitrev()                 : reverse the low nbits of k (used to build twiddle tables)
package ntt_pkg;

   localparam int DEF_W    = 32;
   localparam int DEF_N    = 1024;
   localparam int DEF_LOGN = 10;

   typedef logic [DEF_W-1:0] word_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_TW,
      S_LOAD_DATA,
      S_COMPUTE,
      S_DONE,
      S_OUTPUT
   } state_t;

   function automatic int unsigned bitrev(input int unsigned k, input int unsigned nbits);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < nbits; b++)
         if (k[b]) r = r | (32'd1 << (nbits - 1 - b));
      return r;
   endfunction

endpackage

// File: rtl/ntt_if.sv
// ntt_if: host-side load/start/result bus of the NTT engine.
//   load_w, load_data, start : one-cycle command pulses from the host
//   start_intt               : reserved command, ignored by the engine
//   din                      : load word stream (twiddles, Shoup twiddles, q, coefficients)
//   done                     : one-cycle end-of-compute pulse
//   dout                     : result stream, N words following done
interface ntt_if #(
   parameter int W = 32
) ();

   logic         load_w;
   logic         load_data;
   logic         start;
   logic         start_intt;
   logic [W-1:0] din;
   logic         done;
   logic [W-1:0] dout;

   modport master (
      output load_w, load_data, start, start_intt, din,
      input  done, dout
   );

   modport slave (
      input  load_w, load_data, start, start_intt, din,
      output done, dout
   );

endinterface

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: two-stage Cooley-Tukey butterfly mod q.
//   Stage 1 forms the Shoup quotient estimate Qh = floor(v*wp / 2^W) and the
//   low word of v*w. Stage 2 finishes the modmul (V = v*w mod q) and produces
//   x = (u + V) mod q, y = (u - V) mod q.
//   clk         : clock (datapath registers only, no reset needed)
//   u, v        : operands a[j], a[j+t], both in [0, q)
//   w, wp       : twiddle and its Shoup constant floor(w*2^W/q)
//   q           : modulus, odd and < 2^(W-2)
//   x, y        : registered results, valid two cycles after the inputs
module ntt_butterfly
   import ntt_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic [W-1:0] u,
   input  logic [W-1:0] v,
   input  logic [W-1:0] w,
   input  logic [W-1:0] wp,
   input  logic [W-1:0] q,
   output logic [W-1:0] x,
   output logic [W-1:0] y
);

   logic [2*W-1:0] p_vwp;
   logic [W-1:0]   qh, vw_lo;
   logic [W-1:0]   s1_u, s1_q, s1_qh, s1_vw;

   logic [W-1:0]   qhq_lo, r, vm, x_n, y_n;
   logic [W:0]     sum;

   always_comb begin
      p_vwp = (2*W)'(v) * (2*W)'(wp);
      qh    = W'(p_vwp >> W);
      vw_lo = v * w;  // only the low word matters: the difference below is < 2q
   end

   always_comb begin
      qhq_lo = s1_qh * s1_q;
      r      = s1_vw - qhq_lo;                 // in [0, 2q), exact mod 2^W
      vm     = (r >= s1_q) ? r - s1_q : r;
      sum    = {1'b0, s1_u} + {1'b0, vm};
      x_n    = (sum >= {1'b0, s1_q}) ? W'(sum - {1'b0, s1_q}) : W'(sum);
      y_n    = (s1_u >= vm) ? s1_u - vm : s1_u + s1_q - vm;
   end

   always_ff @(posedge clk) begin
      s1_u  <= u;
      s1_q  <= q;
      s1_qh <= qh;
      s1_vw <= vw_lo;
      x     <= x_n;
      y     <= y_n;
   end

endmodule

// File: rtl/ntt_engine.sv
// ntt_engine: iterative single-butterfly negacyclic forward NTT.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : ntt_if slave port
//     load_w    -> next 2N+1 din words are w[0..N-1], wp[0..N-1], q
//     load_data -> next N din words are a[0..N-1]
//     start     -> in-place Cooley-Tukey NTT over a[], then done pulse,
//                  then a[0..N-1] on dout for N cycles
//     start_intt is reserved and has no effect.
// Butterflies run one at a time and each is written back before the next is
// issued, so no read-after-write hazard exists within or across stages.
// Cost is 3 cycles per butterfly, 1.5*N*log2N total.
module ntt_engine
   import ntt_pkg::*;
#(
   parameter int CIPHER_SIZE   = DEF_W,
   parameter int RING_SIZE     = DEF_N,
   parameter int LOG_RING_SIZE = DEF_LOGN
) (
   input  logic clk,
   input  logic reset,
   ntt_if.slave bus
);

   localparam int W      = CIPHER_SIZE;
   localparam int N      = RING_SIZE;
   localparam int LN     = LOG_RING_SIZE;
   localparam int CW     = LN + 2;   // counts up to 2N for the table load
   localparam int STAGES = 1;        // vld_pipe[k]: butterfly stage k+1 holds the live op

   typedef logic [LN-1:0] idx_t;

   localparam idx_t          ONE     = idx_t'(1);
   localparam idx_t          K_LAST  = idx_t'(N/2 - 1);
   localparam idx_t          S_LAST  = idx_t'(LN - 1);
   localparam logic [CW-1:0] TW_LAST = CW'(2*N);
   localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] N_C     = CW'(N);

   state_t          state;
   logic [CW-1:0]   cnt;
   idx_t            stg;       // butterfly stage, m = 2^stg
   idx_t            bfk;       // butterfly index within the stage, 0..N/2-1
   logic [STAGES:0] vld_pipe;
   logic            done_r;
   logic [W-1:0]    dout_r;

   logic [W-1:0]    q_reg;
   logic [W-1:0]    a_mem  [N];
   logic [W-1:0]    w_mem  [N];
   logic [W-1:0]    wp_mem [N];

   logic            issue, wb;
   idx_t            lt, bi, jlo, j_a, j_b, tw_idx;
   logic [W-1:0]    bf_x, bf_y;
   logic            unused_intt;

   assign unused_intt = bus.start_intt;
   assign bus.done    = done_r;
   assign bus.dout    = dout_r;

   // Map (stage, k) to the butterfly pair: t = 2^lt, i = k / t,
   // j = 2*i*t + k mod t, partner j + t, twiddle index m + i.
   // The bit set by "| (ONE << lt)" is always clear in j_a, and i < m, so OR
   // stands in for addition.
   always_comb begin
      lt     = S_LAST - stg;
      bi     = bfk >> lt;
      jlo    = bfk & ((ONE << lt) - ONE);
      j_a    = (bi << (lt + ONE)) | jlo;
      j_b    = j_a | (ONE << lt);
      tw_idx = (ONE << stg) | bi;
   end

   assign issue = (state == S_COMPUTE) && (vld_pipe == '0);
   assign wb    = (state == S_COMPUTE) && vld_pipe[STAGES];

   ntt_butterfly #(.W(W)) u_bf (
      .clk (clk),
      .u   (a_mem[j_a]),
      .v   (a_mem[j_b]),
      .w   (w_mem[tw_idx]),
      .wp  (wp_mem[tw_idx]),
      .q   (q_reg),
      .x   (bf_x),
      .y   (bf_y)
   );

   // Storage is deliberately not reset so tables survive a reset.
   always_ff @(posedge clk) begin
      if (state == S_LOAD_TW) begin
         if (cnt[LN+1])    q_reg                  <= bus.din;
         else if (cnt[LN]) wp_mem[cnt[LN-1:0]]    <= bus.din;
         else              w_mem[cnt[LN-1:0]]     <= bus.din;
      end
      if (state == S_LOAD_DATA)
         a_mem[cnt[LN-1:0]] <= bus.din;
      if (wb) begin
         a_mem[j_a] <= bf_x;
         a_mem[j_b] <= bf_y;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         stg      <= '0;
         bfk      <= '0;
         vld_pipe <= '0;
         done_r   <= 1'b0;
         dout_r   <= '0;
      end else begin
         done_r   <= 1'b0;
         vld_pipe <= {vld_pipe[STAGES-1:0], issue};
         case (state)
            S_IDLE: begin
               cnt <= '0;
               stg <= '0;
               bfk <= '0;
               if (bus.load_w)         state <= S_LOAD_TW;
               else if (bus.load_data) state <= S_LOAD_DATA;
               else if (bus.start)     state <= S_COMPUTE;
            end
            S_LOAD_TW: begin
               cnt <= cnt + 1'b1;
               if (cnt == TW_LAST) state <= S_IDLE;
            end
            S_LOAD_DATA: begin
               cnt <= cnt + 1'b1;
               if (cnt == N_LAST) state <= S_IDLE;
            end
            S_COMPUTE: begin
               if (wb) begin
                  if (bfk == K_LAST) begin
                     bfk <= '0;
                     if (stg == S_LAST) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                     end else begin
                        stg <= stg + ONE;
                     end
                  end else begin
                     bfk <= bfk + ONE;
                  end
               end
            end
            S_DONE: begin
               dout_r <= a_mem[0];
               cnt    <= CW'(1);
               state  <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (cnt == N_C) begin
                  dout_r <= '0;
                  state  <= S_IDLE;
               end else begin
                  dout_r <= a_mem[cnt[LN-1:0]];
                  cnt    <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_engine.sv
// tb_ntt_engine: directed check of ntt_engine at N=8, W=32, q=17, psi=3.
module tb_ntt_engine;
   import ntt_pkg::*;

   localparam int    N      = 8;
   localparam int    LOGN   = 3;
   localparam int    BUDGET = 2 * N * LOGN;
   localparam word_t Q      = 32'd17;
   localparam int    PSI    = 3;

   logic clk = 1'b0;
   logic reset;

   ntt_if #(.W(32)) bus ();

   ntt_engine #(
      .CIPHER_SIZE   (32),
      .RING_SIZE     (N),
      .LOG_RING_SIZE (LOGN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   word_t w_t  [N];
   word_t wp_t [N];
   word_t coef [N];
   word_t expv [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_tables(input bit with_start);
      @(negedge clk);
      bus.load_w = 1'b1;
      bus.start  = with_start;
      for (int k = 0; k < 2*N+1; k++) begin
         @(negedge clk);
         bus.load_w = 1'b0;
         bus.start  = 1'b0;
         bus.din    = (k < N) ? w_t[k] : (k < 2*N) ? wp_t[k-N] : Q;
      end
      @(negedge clk);
      bus.din = '0;
   endtask

   task automatic load_coeffs();
      @(negedge clk);
      bus.load_data = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         bus.load_data = 1'b0;
         bus.din       = coef[k];
      end
      @(negedge clk);
      bus.din = '0;
   endtask

   // Start, wait for done within budget, then check the N output words.
   // inj > 0 pulses load_data (with junk on din) that many cycles into compute.
   task automatic run_ntt(input string tag, input int inj);
      int cyc;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < BUDGET + 10) begin
         if (bus.done === 1'b1) seen = 1'b1;
         else begin
            if (inj > 0 && cyc == inj) begin
               bus.load_data = 1'b1;
               bus.din       = 32'd9;
            end
            if (inj > 0 && cyc == inj + 1) bus.load_data = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      bus.din = '0;
      chk($sformatf("%s_done_in_budget", tag), 64'(seen && cyc <= BUDGET), 64'd1);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         if (i == 0) chk($sformatf("%s_done_one_cycle", tag), 64'(bus.done), 64'd0);
         chk($sformatf("%s_dout%0d", tag, i), 64'(bus.dout), 64'(expv[i]));
      end
      @(negedge clk);
      chk($sformatf("%s_dout_idle", tag), 64'(bus.dout), 64'd0);
   endtask

   task automatic expect_no_done(input string tag, input int ncyc);
      int seen;
      seen = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      // twiddle tables built from psi and q
      for (int k = 0; k < N; k++) begin
         int unsigned e, p;
         e = bitrev(k, LOGN);
         p = 1;
         repeat (e) p = (p * PSI) % 17;
         w_t[k]  = word_t'(p);
         wp_t[k] = word_t'((64'(w_t[k]) << 32) / 64'(Q));
      end

      reset          = 1'b1;
      bus.load_w     = 1'b0;
      bus.load_data  = 1'b0;
      bus.start      = 1'b0;
      bus.start_intt = 1'b0;
      bus.din        = '0;
      repeat (3) @(negedge clk);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_dout", 64'(bus.dout), 64'd0);
      reset = 1'b0;

      // 1. impulse
      load_tables(1'b0);
      coef = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{1, 1, 1, 1, 1, 1, 1, 1};
      run_ntt("impulse", 0);

      // 2. shift
      coef = '{0, 1, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{3, 14, 5, 12, 10, 7, 11, 6};
      run_ntt("shift", 0);

      // 3. reload data only
      coef = '{2, 0, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{2, 2, 2, 2, 2, 2, 2, 2};
      run_ntt("const2", 0);
      coef = '{0, 2, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{6, 11, 10, 7, 3, 14, 5, 12};
      run_ntt("shift2", 0);

      // 4. reset mid-compute, then recompute with retained tables
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midreset_done", 64'(bus.done), 64'd0);
      chk("midreset_dout", 64'(bus.dout), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expect_no_done("midreset_no_done", 50);
      coef = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{1, 1, 1, 1, 1, 1, 1, 1};
      run_ntt("after_reset", 0);

      // 5a. load_data during compute is ignored
      coef = '{0, 1, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{3, 14, 5, 12, 10, 7, 11, 6};
      run_ntt("ld_in_compute", 5);

      // 5b. start_intt alone does nothing
      @(negedge clk);
      bus.start_intt = 1'b1;
      @(negedge clk);
      bus.start_intt = 1'b0;
      expect_no_done("intt_no_done", 50);
      chk("intt_dout", 64'(bus.dout), 64'd0);

      // 5c. load_w + start together: table load only
      load_tables(1'b1);
      expect_no_done("lw_start_no_done", 50);
      coef = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_coeffs();
      expv = '{1, 1, 1, 1, 1, 1, 1, 1};
      run_ntt("after_lw_start", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
